// File: rtl/best_score_seq_if.sv
// rtl/best_score_seq_if.sv - score stream in / result out handshake bundle for best_score_seq
// out_score exists only when BEST_SCORE_SCORE_OUT_EN is defined.
interface best_score_seq_if #(
   parameter int SCORE_W = 64,
   parameter int MODE_W  = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic signed [SCORE_W-1:0] in_score;
   logic                      in_last;
   logic                      out_valid;
   logic                      out_ready;
   logic [MODE_W-1:0]         out_mode;
   logic [MODE_W-1:0]         out_count;
`ifdef BEST_SCORE_SCORE_OUT_EN
   logic signed [SCORE_W-1:0] out_score;
`endif

   modport master (
      output in_valid, in_score, in_last, out_ready,
`ifdef BEST_SCORE_SCORE_OUT_EN
      input  out_score,
`endif
      input  in_ready, out_valid, out_mode, out_count
   );

   modport slave (
      input  in_valid, in_score, in_last, out_ready,
`ifdef BEST_SCORE_SCORE_OUT_EN
      output out_score,
`endif
      output in_ready, out_valid, out_mode, out_count
   );
endinterface

// File: rtl/best_score_seq.sv
// rtl/best_score_seq.sv - streaming running-minimum selector, lowest index wins ties
// Optional winning-score output register: define BEST_SCORE_SCORE_OUT_EN.
module best_score_seq #(
   parameter int SCORE_W   = 64,
   parameter int NUM_MODES = 10,
   parameter int MODE_W    = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          flush,
   best_score_seq_if.slave bus
);
   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t                    state;
   logic [MODE_W-1:0]         cnt;
   logic [MODE_W-1:0]         best_idx;
   logic signed [SCORE_W-1:0] best;
   logic                      valid_q;
   logic [MODE_W-1:0]         mode_q;
   logic [MODE_W-1:0]         count_q;
`ifdef BEST_SCORE_SCORE_OUT_EN
   logic signed [SCORE_W-1:0] score_q;
`endif

   logic                      accept;
   logic                      close;
   logic                      take;
   logic [MODE_W-1:0]         nxt_idx;
   logic signed [SCORE_W-1:0] nxt_best;

   assign bus.in_ready  = (state == COLLECT);
   assign bus.out_valid = valid_q;
   assign bus.out_mode  = mode_q;
   assign bus.out_count = count_q;
`ifdef BEST_SCORE_SCORE_OUT_EN
   assign bus.out_score = score_q;
`endif

   // Best state as it stands after the current beat, so the closing beat competes too.
   always_comb begin
      accept   = bus.in_valid && (state == COLLECT);
      close    = bus.in_last || (cnt == MODE_W'(NUM_MODES - 1));
      take     = (cnt == '0) || (bus.in_score < best);
      nxt_best = take ? bus.in_score : best;
      nxt_idx  = take ? cnt : best_idx;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= COLLECT;
         cnt      <= '0;
         best     <= '0;
         best_idx <= '0;
         valid_q  <= 1'b0;
         mode_q   <= '0;
         count_q  <= '0;
`ifdef BEST_SCORE_SCORE_OUT_EN
         score_q  <= '0;
`endif
      end else if (flush) begin
         state   <= COLLECT;
         cnt     <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  best     <= nxt_best;
                  best_idx <= nxt_idx;
                  if (close) begin
                     mode_q  <= nxt_idx;
                     count_q <= cnt + MODE_W'(1);
`ifdef BEST_SCORE_SCORE_OUT_EN
                     score_q <= nxt_best;
`endif
                     valid_q <= 1'b1;
                     cnt     <= '0;
                     state   <= HOLD;
                  end else begin
                     cnt <= cnt + MODE_W'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  state   <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_best_score_seq.sv
// tb/tb_best_score_seq.sv - directed self-checking bench for best_score_seq
// Drives at posedge+1, samples at posedge+1; out_score checks only with BEST_SCORE_SCORE_OUT_EN.
module tb_best_score_seq;
   localparam int SW = 64;
   localparam int MW = 8;
   localparam int NM = 10;

   logic clk = 1'b0;
   logic rstn;
   logic flush;
   int   n_cmp = 0;
   int   n_err = 0;
   int   t1 [10] = '{5, 3, 7, 3, 9, 8, 6, 4, 10, 11};

   always #5 clk = ~clk;

   best_score_seq_if #(.SCORE_W(SW), .MODE_W(MW)) bus_if ();

   best_score_seq #(.SCORE_W(SW), .NUM_MODES(NM), .MODE_W(MW)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .bus   (bus_if)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] s, input logic last);
      bus_if.in_valid = 1'b1;
      bus_if.in_score = s;
      bus_if.in_last  = last;
      tick();
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
   endtask

   task automatic result(input string tag, input logic [63:0] mode, input logic [63:0] count,
                         input logic [63:0] score);
      check({tag, "_valid"}, 64'(bus_if.out_valid), 64'd1);
      check({tag, "_ready"}, 64'(bus_if.in_ready), 64'd0);
      check({tag, "_mode"}, 64'(bus_if.out_mode), mode);
      check({tag, "_count"}, 64'(bus_if.out_count), count);
`ifdef BEST_SCORE_SCORE_OUT_EN
      check({tag, "_score"}, 64'(bus_if.out_score), score);
`else
      if (score === 64'hx) $display("unexpected x score");
`endif
   endtask

   task automatic release_result(input string tag);
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      bus_if.in_valid  = 1'b0;
      check({tag, "_rel_valid"}, 64'(bus_if.out_valid), 64'd0);
      check({tag, "_rel_ready"}, 64'(bus_if.in_ready), 64'd1);
   endtask

   initial begin
      rstn             = 1'b0;
      flush            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_score  = '0;
      bus_if.in_last   = 1'b0;
      bus_if.out_ready = 1'b0;
      #2;
      check("rst_valid", 64'(bus_if.out_valid), 64'd0);
      check("rst_mode", 64'(bus_if.out_mode), 64'd0);
      check("rst_count", 64'(bus_if.out_count), 64'd0);
      check("rst_ready", 64'(bus_if.in_ready), 64'd1);
      repeat (2) tick();
      rstn = 1'b1;
      tick();

      // mixed scores with a tie at index 3, closed by in_last on the tenth beat
      for (int i = 0; i < 10; i++) begin
         beat(64'(t1[i]), i == 9);
         if (i == 8) check("t1_early_valid", 64'(bus_if.out_valid), 64'd0);
      end
      result("t1", 64'd1, 64'd10, 64'd3);
      release_result("t1");

      // all equal, auto-close at NUM_MODES
      for (int i = 0; i < 10; i++) beat(-64'sd2, 1'b0);
      result("t2", 64'd0, 64'd10, -64'sd2);
      release_result("t2");

      // back-pressure with junk beats offered during HOLD
      beat(64'd100, 1'b0);
      beat(-64'sd5, 1'b0);
      beat(64'd0, 1'b0);
      beat(-64'sd6, 1'b1);
      bus_if.in_valid = 1'b1;
      bus_if.in_score = -64'sd100;
      bus_if.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         result("t3_hold", 64'd3, 64'd4, -64'sd6);
         tick();
      end
      bus_if.in_last = 1'b0;
      release_result("t3");
      check("t3_kept_mode", 64'(bus_if.out_mode), 64'd3);

      // signed extremes
      beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      beat(64'h8000_0000_0000_0000, 1'b1);
      result("t4", 64'd2, 64'd3, 64'h8000_0000_0000_0000);
      release_result("t4");

      // flush on beat 2 of a burst discards it
      beat(64'd4, 1'b0);
      flush = 1'b1;
      beat(-64'sd50, 1'b0);
      flush = 1'b0;
      check("t5_flush_valid", 64'(bus_if.out_valid), 64'd0);
      beat(64'd9, 1'b0);
      beat(64'd1, 1'b1);
      result("t5", 64'd1, 64'd2, 64'd1);
      release_result("t5");

      // flush while holding a result drops valid but keeps result registers
      beat(64'd8, 1'b0);
      beat(-64'sd3, 1'b1);
      result("t6", 64'd1, 64'd2, -64'sd3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t6_flush_valid", 64'(bus_if.out_valid), 64'd0);
      check("t6_flush_ready", 64'(bus_if.in_ready), 64'd1);
      check("t6_kept_mode", 64'(bus_if.out_mode), 64'd1);
      check("t6_kept_count", 64'(bus_if.out_count), 64'd2);

      // asynchronous reset during HOLD
      beat(64'd6, 1'b0);
      beat(64'd2, 1'b1);
      result("t7_pre", 64'd1, 64'd2, 64'd2);
      #2;
      rstn = 1'b0;
      #1;
      check("t7_rst_valid", 64'(bus_if.out_valid), 64'd0);
      check("t7_rst_ready", 64'(bus_if.in_ready), 64'd1);
      check("t7_rst_count", 64'(bus_if.out_count), 64'd0);
      tick();
      rstn = 1'b1;
      tick();
      beat(64'd7, 1'b1);
      result("t7", 64'd0, 64'd1, 64'd7);
      release_result("t7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/best_score_seq.md
# best_score_seq

Streaming, parametrised best-score selector. Takes one signed score per cycle over a valid/ready handshake, tracks the running minimum and its position, and presents the winning mode index once the burst closes. Ties resolve to the lowest index. Sits between the per-mode cost pipelines and the mode-decision logic, and replaces the fixed 10-input combinational selector where scores arrive serially.

## Interface
Parameters:
- SCORE_W, 64, width of a signed score.
- NUM_MODES, 10, maximum candidates per burst; legal range 2..2^MODE_W-1.
- MODE_W, 8, width of mode index and count outputs.

Ports:
- clk  in  1  clock; single clock domain, all logic rising-edge.
- rstn  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous abort of the partial burst and any held result.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block can accept a beat.
- in_score  in  SCORE_W  signed score, two's complement.
- in_last  in  1  final beat of the burst.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_mode  out  MODE_W  index of the winning candidate within the burst.
- out_count  out  MODE_W  number of candidates in the burst.
- out_score  out  SCORE_W  winning score (present only with BEST_SCORE_SCORE_OUT_EN).

## Operation
- Two states: COLLECT and HOLD. Reset state is COLLECT.
- in_ready = (state == COLLECT). A beat is accepted when in_valid && in_ready.
- Per accepted beat:
  - idx = cnt, where cnt is the beats accepted so far in this burst.
  - The first beat of the burst (cnt == 0) loads best = in_score and best_idx = 0.
  - Later beats replace best and best_idx only when in_score < best (strict signed compare). Equal scores therefore keep the earlier index.
  - cnt increments by 1.
- Burst close: an accepted beat with in_last = 1, or the accepted beat that makes cnt == NUM_MODES (auto-close, in_last ignored).
  - On close, the result registers load out_mode, out_count and out_score from the final best state, including the closing beat itself.
  - out_valid goes high, cnt clears, and the state moves to HOLD.
- HOLD: outputs are stable and in_ready is 0. On out_valid && out_ready, out_valid drops and the state returns to COLLECT.
- Empty bursts cannot occur; every burst has at least one beat.
- flush (priority over everything):
  - Next cycle: cnt = 0, out_valid = 0, state = COLLECT. Result registers keep their values.
  - A beat accepted in the same cycle as flush is discarded.
  - A result handshake in the same cycle as flush is treated as done.
- Signed compare is performed at the full SCORE_W width. No saturation or truncation.

## Timing
- Reset values:
  - Registered outputs: out_valid 0, out_mode 0, out_count 0, out_score 0.
  - Internal: cnt 0, state COLLECT.
  - in_ready is combinational from state, so it is 1 during and after reset.
- Latency: out_valid is asserted on the clock edge that accepts the closing beat, and is visible the cycle after that beat.
- There is no bypass from HOLD to COLLECT. The next burst's first beat is accepted at the earliest one cycle after the output handshake.
- Minimum burst period is K+1 cycles for a K-beat burst with out_ready held at 1.
- Reset asserted mid-burst or in HOLD returns all state to the reset values immediately (asynchronous).
- in_score and in_last are sampled only on accepted beats.

## Configuration
- BEST_SCORE_SCORE_OUT_EN defined: the out_score port and its result register exist. out_score holds the winning score while out_valid = 1.
- Not defined: the out_score port is absent and its result register is removed. All other behaviour is identical, including the internal best tracking.

## Test plan
- Ten beats 5,3,7,3,9,8,6,4,10,11, with in_last on beat 9 -> out_mode 1, out_count 10, out_score 3, out_valid one cycle after beat 9.
- Ten beats, no in_last, all equal to -2 -> auto-close on the 10th beat, out_mode 0, out_count 10.
- Four beats 100,-5,0,-6 with in_last on beat 3; out_ready held 0 for 5 cycles -> out_mode 3, out_count 4, out_score -6. in_ready stays 0 and the outputs stay stable until the handshake, then in_ready returns to 1 one cycle later.
- Signed extremes -2^63 (last of 3 beats) against 2^63-1 -> out_mode 2, out_score -2^63.
- flush asserted on beat 2 of a burst, then a fresh burst 9,1 with in_last -> the flushed beats are not counted; out_mode 1, out_count 2.
- rstn pulsed low during HOLD -> out_valid 0 and in_ready 1 immediately. The next burst 7 (in_last) -> out_mode 0, out_count 1.
